pwm_duty_ramp: RTL and testbench

//  Upstream feeder for the PWM stage. It captures 4-bit ALU results through a

---
 rtl/pwm_duty_ramp.sv | 122 ++++++++++++
 tb/tb_pwm_duty_ramp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Duty slew limiter: captures a target over valid/ready and steps duty_out one LSB
// every STEP_CYCLES clocks toward it. Define DUTY_RAMP_RETARGET_EN to accept new targets mid-ramp.
module pwm_duty_ramp #(
    parameter int WIDTH       = 4,
    parameter int STEP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] duty_out,
    output logic             busy,
    output logic             at_target
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] target_r, target_s;
    logic [WIDTH-1:0] duty_r, duty_s;
    logic [WIDTH-1:0] goal_s;
    logic [TW-1:0]    tick_r, tick_s;
    logic             xfer_s;

    // Ready decode: depends on state only, never on alu_valid.
    always_comb begin
`ifdef DUTY_RAMP_RETARGET_EN
        alu_ready = 1'b1;
`else
        case (state_r)
            IDLE:    alu_ready = 1'b1;
            RAMP:    alu_ready = 1'b0;
            default: alu_ready = 1'b0;
        endcase
`endif
    end

    assign xfer_s = alu_valid & alu_ready;

    // Next-state, target capture and step cadence.
    always_comb begin
        state_s  = state_r;
        target_s = target_r;
        duty_s   = duty_r;
        tick_s   = tick_r;
        goal_s   = target_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    target_s = alu_result;
                    tick_s   = {TW{1'b0}};
                    if (alu_result != duty_r) begin
                        state_s = RAMP;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RAMP: begin
`ifdef DUTY_RAMP_RETARGET_EN
                // A new target steers the step taken on this very edge.
                if (xfer_s) begin
                    target_s = alu_result;
                    goal_s   = alu_result;
                end else begin
                    goal_s   = target_r;
                end
`endif
                if (goal_s == duty_r) begin
                    state_s = IDLE;
                    tick_s  = {TW{1'b0}};
                end else if (tick_r == TICK_LAST) begin
                    tick_s = {TW{1'b0}};
                    if (goal_s > duty_r) begin
                        duty_s = duty_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        duty_s = duty_r - {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (duty_s == goal_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RAMP;
                    end
                end else begin
                    tick_s = tick_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers; reset drops duty to zero immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            target_r <= {WIDTH{1'b0}};
            duty_r   <= {WIDTH{1'b0}};
            tick_r   <= {TW{1'b0}};
        end else begin
            state_r  <= state_s;
            target_r <= target_s;
            duty_r   <= duty_s;
            tick_r   <= tick_s;
        end
    end

    assign duty_out  = duty_r;
    assign busy      = (state_r == RAMP);
    assign at_target = (duty_r == target_r);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp (STEP_CYCLES=4): stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_pwm_duty_ramp;

    logic       clk;
    logic       rst;
    logic       alu_valid;
    logic       alu_ready;
    logic [3:0] alu_result;
    logic [3:0] duty_out;
    logic       busy;
    logic       at_target;

    int cyc    = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int         c;
        logic [3:0] duty;
        logic       busy;
        logic       rdy;
        logic       at;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    pwm_duty_ramp #(.WIDTH(4), .STEP_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_result (alu_result),
        .duty_out   (duty_out),
        .busy       (busy),
        .at_target  (at_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_rdy(input logic b);
`ifdef DUTY_RAMP_RETARGET_EN
        return 1'b1;
`else
        return ~b;
`endif
    endfunction

    task automatic push(input string name, input int c, input logic [3:0] d,
                        input logic b, input logic at);
        exp_t e;
        e.c = c; e.duty = d; e.busy = b; e.rdy = exp_rdy(b); e.at = at; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives one valid cycle; returns the number of the capturing edge.
    task automatic send(input logic [3:0] v, output int e0);
        @(negedge clk);
        alu_valid  = 1'b1;
        alu_result = v;
        e0 = cyc + 1;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.c < cyc) begin
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.c, cyc);
            end else if (duty_out !== e.duty || busy !== e.busy ||
                         alu_ready !== e.rdy || at_target !== e.at) begin
                $display("FAIL %s @%0d: got duty=%0d busy=%b ready=%b at=%b, expected duty=%0d busy=%b ready=%b at=%b",
                         e.name, cyc, duty_out, busy, alu_ready, at_target,
                         e.duty, e.busy, e.rdy, e.at);
            end else begin
                passed++;
            end
        end
    end

    initial begin
        int e0;
        rst        = 1'b0;
        alu_valid  = 1'b0;
        alu_result = 4'd0;

        // 1. reset state, then release
        for (int i = 1; i <= 4; i++) push("reset", i, 4'd0, 1'b0, 1'b1);
        wait_to(2);
        rst = 1'b1;
        wait_to(4);

        // 2. ramp 0 -> 15
        send(4'd15, e0);
        push("up_start", e0, 4'd0, 1'b1, 1'b0);
        push("up_hold", e0 + 3, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++)
            push("up_step", e0 + 4 * k, 4'(k), (k != 15), (k == 15));
        drop_valid();
        wait_to(e0 + 61);

        // 3. ramp 15 -> 9
        send(4'd9, e0);
        for (int k = 1; k <= 6; k++)
            push("down_step", e0 + 4 * k, 4'(15 - k), (k != 6), (k == 6));
        drop_valid();
        wait_to(e0 + 25);

        // 4. same target: no ramp
        send(4'd9, e0);
        push("same_e0", e0, 4'd9, 1'b0, 1'b1);
        push("same_e1", e0 + 1, 4'd9, 1'b0, 1'b1);
        push("same_e4", e0 + 4, 4'd9, 1'b0, 1'b1);
        push("same_e8", e0 + 8, 4'd9, 1'b0, 1'b1);
        drop_valid();
        wait_to(e0 + 9);

        // back to 0 for the next scenario
        send(4'd0, e0);
        push("to_zero", e0 + 36, 4'd0, 1'b0, 1'b1);
        drop_valid();
        wait_to(e0 + 37);

        // 5. ramp 0 -> 15 with a retarget pulse to 3 at E10
        send(4'd15, e0);
        push("rt_pre", e0 + 8, 4'd2, 1'b1, 1'b0);
        drop_valid();
        wait_to(e0 + 9);
        alu_valid  = 1'b1;
        alu_result = 4'd3;
`ifdef DUTY_RAMP_RETARGET_EN
        push("rt_e10", e0 + 10, 4'd2, 1'b1, 1'b0);
        push("rt_e11", e0 + 11, 4'd2, 1'b1, 1'b0);
        push("rt_e12", e0 + 12, 4'd3, 1'b0, 1'b1);
        push("rt_e20", e0 + 20, 4'd3, 1'b0, 1'b1);
        push("rt_e60", e0 + 60, 4'd3, 1'b0, 1'b1);
`else
        push("rt_e10", e0 + 10, 4'd2, 1'b1, 1'b0);
        push("rt_e12", e0 + 12, 4'd3, 1'b1, 1'b0);
        push("rt_e16", e0 + 16, 4'd4, 1'b1, 1'b0);
        push("rt_e59", e0 + 59, 4'd14, 1'b1, 1'b0);
        push("rt_e60", e0 + 60, 4'd15, 1'b0, 1'b1);
`endif
        drop_valid();
        wait_to(e0 + 61);

        // synchronous-style reset pulse back to 0
        rst = 1'b0;
        push("rst_pulse", cyc + 1, 4'd0, 1'b0, 1'b1);
        wait_to(cyc + 2);
        rst = 1'b1;

        // 6. asynchronous reset mid-ramp between E20 and E21
        send(4'd15, e0);
        push("ar_e16", e0 + 16, 4'd4, 1'b1, 1'b0);
        push("ar_e19", e0 + 19, 4'd4, 1'b1, 1'b0);
        push("ar_async", e0 + 20, 4'd0, 1'b0, 1'b1);
        push("ar_hold", e0 + 21, 4'd0, 1'b0, 1'b1);
        drop_valid();
        wait_to(e0 + 19);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_to(e0 + 22);
        rst = 1'b1;
        push("ar_after", e0 + 24, 4'd0, 1'b0, 1'b1);
        wait_to(e0 + 26);

        // anything left in the queue was never compared
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.c);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
